// File: rtl/sr_latch_sequencer.sv
// Sequences set/clear pulses onto an external SR latch, waits for it to settle,
// then verifies the synchronized Q/QB readback and acknowledges the operation.
// State table: IDLE = wait for a pending request | PULSE = drive S or R |
//              SETTLE = drives low, latch settling | CHECK = compare readback, ack
module sr_latch_sequencer #(
  parameter int PULSE_W  = 4,
  parameter int SETTLE_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic err_clr,
  input  logic latch_q,
  input  logic latch_qb,
  output logic latch_s,
  output logic latch_r,
  output logic set_ack,
  output logic clr_ack,
  output logic busy,
  output logic state_q,
  output logic err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_W - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_W - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_q_s1;
  logic       r_q_s2;
  logic       r_qb_s1;
  logic       r_qb_s2;
  logic       r_pend_set;
  logic       r_pend_clr;
  // r_op_set doubles as the round-robin pointer: it holds the most recent grant.
  logic       r_op_set;
  logic       w_op_set_nxt;
  logic       w_grant;
  logic       w_grant_set;
  logic       w_check;
  logic       w_match;
  logic       w_pend_set_nxt;
  logic       w_pend_clr_nxt;
  logic       w_err_nxt;
  logic       w_state_q_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_grant      = 1'b0;
    w_grant_set  = 1'b0;
    w_op_set_nxt = r_op_set;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_set || r_pend_clr) begin
          w_grant      = 1'b1;
          w_grant_set  = (r_pend_set && r_pend_clr) ? ~r_op_set : r_pend_set;
          w_op_set_nxt = w_grant_set;
          w_state_nxt  = ST_PULSE;
          w_cnt_nxt    = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = SETTLE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_CHECK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // A q==qb readback never matches either expected pattern.
  assign w_check        = (r_state == ST_CHECK);
  assign w_match        = r_op_set ? (r_q_s2 & ~r_qb_s2) : (~r_q_s2 & r_qb_s2);
  assign w_err_nxt      = (w_check & ~w_match) | (err & ~err_clr);
  assign w_state_q_nxt  = (w_check & w_match) ? r_op_set : state_q;
  assign w_pend_set_nxt = (r_pend_set & ~(w_grant & w_grant_set)) | set_req;
  assign w_pend_clr_nxt = (r_pend_clr & ~(w_grant & ~w_grant_set)) | clr_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_q_s1     <= 1'b0;
      r_q_s2     <= 1'b0;
      r_qb_s1    <= 1'b0;
      r_qb_s2    <= 1'b0;
      r_pend_set <= 1'b0;
      r_pend_clr <= 1'b0;
      r_op_set   <= 1'b0;
      latch_s    <= 1'b0;
      latch_r    <= 1'b0;
      set_ack    <= 1'b0;
      clr_ack    <= 1'b0;
      busy       <= 1'b0;
      state_q    <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_q_s1     <= latch_q;
      r_q_s2     <= r_q_s1;
      r_qb_s1    <= latch_qb;
      r_qb_s2    <= r_qb_s1;
      r_pend_set <= w_pend_set_nxt;
      r_pend_clr <= w_pend_clr_nxt;
      r_op_set   <= w_op_set_nxt;
      latch_s    <= (w_state_nxt == ST_PULSE) &  w_op_set_nxt;
      latch_r    <= (w_state_nxt == ST_PULSE) & ~w_op_set_nxt;
      set_ack    <= (w_state_nxt == ST_CHECK) &  w_op_set_nxt;
      clr_ack    <= (w_state_nxt == ST_CHECK) & ~w_op_set_nxt;
      busy       <= (w_state_nxt != ST_IDLE);
      state_q    <= w_state_q_nxt;
      err        <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Bench for sr_latch_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an operation-timeline model.
module tb_sr_latch_sequencer;
  localparam int PW   = 4;
  localparam int SW   = 3;
  localparam int LAST = PW + SW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0, clr_req = 1'b0, err_clr = 1'b0;
  logic latch_q = 1'b0, latch_qb = 1'b1;
  logic latch_s, latch_r, set_ack, clr_ack, busy, state_q, err;

  int checks = 0;
  int failures = 0;
  int mode = 0;  // 0 healthy latch, 1 stuck 11, 2 stuck 00, 3 inverted

  always #5 clk = ~clk;

  sr_latch_sequencer #(.PULSE_W(PW), .SETTLE_W(SW)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .err_clr(err_clr),
    .latch_q(latch_q), .latch_qb(latch_qb), .latch_s(latch_s), .latch_r(latch_r),
    .set_ack(set_ack), .clr_ack(clr_ack), .busy(busy), .state_q(state_q), .err(err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the grant edge (0 = idle, LAST = check cycle).
  bit m_valid = 0;
  int m_t = 0;
  bit m_op = 0, m_ps = 0, m_pc = 0, m_sq = 0, m_err = 0;
  bit m_q1 = 0, m_q2 = 0, m_qb1 = 0, m_qb2 = 0;
  wire m_ok   = m_op ? (m_q2 && !m_qb2) : (!m_q2 && m_qb2);
  wire m_gnt  = (m_t == 0) && (m_ps || m_pc);
  wire m_gset = (m_ps && m_pc) ? !m_op : m_ps;
  wire e_drv  = (m_t >= 1) && (m_t <= PW);

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1; m_t <= 0; m_op <= 0; m_ps <= 0; m_pc <= 0; m_sq <= 0; m_err <= 0;
      m_q1 <= 0; m_q2 <= 0; m_qb1 <= 0; m_qb2 <= 0;
    end else begin
      m_q1 <= latch_q; m_q2 <= m_q1; m_qb1 <= latch_qb; m_qb2 <= m_qb1;
      if (m_t == LAST && m_ok) m_sq <= m_op;
      m_err <= (m_t == LAST && !m_ok) ? 1'b1 : (err_clr ? 1'b0 : m_err);
      if (m_gnt) begin
        m_op <= m_gset;
        m_t  <= 1;
      end else if (m_t != 0) begin
        m_t <= (m_t == LAST) ? 0 : m_t + 1;
      end
      m_ps <= (m_ps && !(m_gnt && m_gset)) || set_req;
      m_pc <= (m_pc && !(m_gnt && !m_gset)) || clr_req;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("latch_s", latch_s, int'(m_op && e_drv));
      chk("latch_r", latch_r, int'(!m_op && e_drv));
      chk("set_ack", set_ack, int'(m_op && m_t == LAST));
      chk("clr_ack", clr_ack, int'(!m_op && m_t == LAST));
      chk("busy", busy, int'(m_t != 0));
      chk("state_q", state_q, int'(m_sq));
      chk("err", err, int'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk);
    case (mode)
      0: begin
        if (latch_s) begin latch_q = 1'b1; latch_qb = 1'b0; end
        else if (latch_r) begin latch_q = 1'b0; latch_qb = 1'b1; end
      end
      1: begin latch_q = 1'b1; latch_qb = 1'b1; end
      2: begin latch_q = 1'b0; latch_qb = 1'b0; end
      default: begin
        if (latch_s) begin latch_q = 1'b0; latch_qb = 1'b1; end
        else if (latch_r) begin latch_q = 1'b1; latch_qb = 1'b0; end
      end
    endcase
  endtask

  int first_s, first_r, first_sack, first_cack, n_s, n_r, n_sack, n_cack, both;

  // Runs n cycles after requests were driven, recording when things happen.
  // With rep set, set_req is re-pulsed on cycles 2, 4 and 6.
  task automatic run_win(input int n, input bit rep);
    first_s = -1; first_r = -1; first_sack = -1; first_cack = -1;
    n_s = 0; n_r = 0; n_sack = 0; n_cack = 0; both = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      set_req = rep && (k == 2 || k == 4 || k == 6);
      clr_req = 1'b0;
      err_clr = 1'b0;
      if (latch_s) begin n_s++; if (first_s < 0) first_s = k; end
      if (latch_r) begin n_r++; if (first_r < 0) first_r = k; end
      if (set_ack) begin n_sack++; if (first_sack < 0) first_sack = k; end
      if (clr_ack) begin n_cack++; if (first_cack < 0) first_cack = k; end
      if (latch_s && latch_r) both++;
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    chk("reset_busy", busy, 0);
    chk("reset_state_q", state_q, 0);
    chk("reset_err", err, 0);

    // single set with healthy latch
    set_req = 1'b1; run_win(14, 0);
    chk("set_first_drive", first_s, 2);
    chk("set_drive_len", n_s, 4);
    chk("set_ack_cycle", first_sack, 9);
    chk("set_ack_count", n_sack, 1);
    chk("set_state_q", state_q, 1);
    chk("set_err", err, 0);

    // clear against a latch stuck at q=qb=1
    mode = 1; clr_req = 1'b1; run_win(14, 0);
    chk("stuck_clr_ack_cycle", first_cack, 9);
    chk("stuck_clr_drive_len", n_r, 4);
    chk("stuck_err", err, 1);
    chk("stuck_state_q", state_q, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr_next", err, 0);

    // mismatch in the same cycle as err_clr
    clr_req = 1'b1; guard = 0;
    do begin tick(); clr_req = 1'b0; guard++; end while (!clr_ack && guard < 20);
    chk("mismatch_ack_seen", int'(clr_ack), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("mismatch_beats_err_clr", err, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr_after", err, 0);
    tick();

    // simultaneous set and clear
    mode = 0; set_req = 1'b1; clr_req = 1'b1; run_win(22, 0);
    chk("tie_set_first", first_s, 2);
    chk("tie_set_ack", first_sack, 9);
    chk("tie_clr_drive", first_r, 11);
    chk("tie_clr_ack", first_cack, 18);
    chk("tie_no_overlap", both, 0);
    chk("tie_state_q", state_q, 0);

    // reset in the second pulse cycle
    set_req = 1'b1; tick(); set_req = 1'b0; tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_latch_s", latch_s, 0);
    chk("rst_mid_busy", busy, 0);
    run_win(6, 0);
    chk("rst_mid_no_ack", n_sack + n_cack, 0);
    set_req = 1'b1; run_win(14, 0);
    chk("rst_mid_recover_ack", n_sack, 1);
    chk("rst_mid_recover_state_q", state_q, 1);

    // repeated set requests while busy merge into one further operation
    set_req = 1'b1; run_win(30, 1);
    chk("merge_set_acks", n_sack, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      set_req = ($urandom_range(0, 7) == 0);
      clr_req = ($urandom_range(0, 7) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 3);
    end
    set_req = 1'b0; clr_req = 1'b0; err_clr = 1'b0; rst = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_latch_sequencer.md
SR_LATCH_SEQUENCER -- requirements
Module: sr_latch_sequencer

Interface
REQ-001 SHALL have parameter PULSE_W, default 4, S/R drive pulse length in clk cycles (legal 1..15).
REQ-002 SHALL have parameter SETTLE_W, default 3, post-pulse settle length in clk cycles (legal 1..15).
REQ-003 SHALL have ports as follows; one clock, reset synchronous active-high:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- set_req  in  1  one-cycle pulse, request latch set
- clr_req  in  1  one-cycle pulse, request latch reset
- err_clr  in  1  clears sticky error
- latch_q  in  1  latch Q readback, asynchronous to clk
- latch_qb  in  1  latch QB readback, asynchronous to clk
- latch_s  out  1  drive to latch S input
- latch_r  out  1  drive to latch R input
- set_ack  out  1  one-cycle completion of a set operation
- clr_ack  out  1  one-cycle completion of a clear operation
- busy  out  1  high in any state other than IDLE
- state_q  out  1  last verified latch value
- err  out  1  sticky readback-mismatch flag

Function
REQ-004 SHALL pass latch_q and latch_qb each through a 2-flop synchronizer before any use.
REQ-005 SHALL capture set_req and clr_req into pend_set and pend_clr flags in every state; a request while the same flag is already set SHALL be merged, not queued.
REQ-006 SHALL implement FSM states IDLE, PULSE, SETTLE, CHECK.
REQ-007 IDLE: if any pending flag is set, SHALL grant one, clear its flag that edge, and go to PULSE; otherwise stay in IDLE.
REQ-008 Tie, both flags pending: SHALL grant opposite of last grant (round-robin pointer); pointer reset value SHALL favour set.
REQ-009 A request arriving in the same cycle its pending flag is cleared by grant SHALL remain pending.
REQ-010 PULSE: SHALL hold latch_s (set grant) or latch_r (clear grant) high for exactly PULSE_W cycles, then go to SETTLE.
REQ-011 latch_s and latch_r SHALL never be high in the same cycle, and both SHALL be low outside PULSE.
REQ-012 SETTLE: SHALL hold both drives low for exactly SETTLE_W cycles, then go to CHECK.
REQ-013 CHECK (one cycle): SHALL compare synchronized readback against expected (set: q=1,qb=0; clear: q=0,qb=1), then return to IDLE.
REQ-014 CHECK match: SHALL load state_q with expected value; mismatch, including q==qb, SHALL set err and leave state_q unchanged.
REQ-015 SHALL assert set_ack or clr_ack (per grant) for the CHECK cycle only, on match or mismatch.
REQ-016 Latency: grant edge to ack cycle SHALL be PULSE_W+SETTLE_W+1 cycles; back-to-back operations SHALL have exactly one IDLE cycle between them.
REQ-017 err_clr SHALL clear err the next edge; a mismatch in the same cycle as err_clr SHALL win (err stays 1).
REQ-018 PULSE and SETTLE counters SHALL be 4 bits and SHALL not wrap within legal parameter range.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 On rst high at a clk edge: state IDLE, latch_s=0, latch_r=0, set_ack=0, clr_ack=0, busy=0, state_q=0, err=0, pending flags cleared, pointer favours set, synchronizers cleared.
REQ-021 rst mid-PULSE SHALL drop the active drive at that edge and abandon the operation with no ack.
REQ-022 rst SHALL take priority over all other inputs, including requests and err_clr in the same cycle.

Verification
REQ-023 Scenario: reset, set_req pulse, model q=1/qb=0 -> latch_s high 4 cycles, 3 low, set_ack at cycle 8 after grant, state_q=1, err=0.
REQ-024 Scenario: set_req and clr_req same cycle after reset -> set granted first, clr second after one IDLE cycle, never latch_s&latch_r.
REQ-025 Scenario: clr_req with readback stuck q=1/qb=1 -> clr_ack pulses, err=1, state_q unchanged; err_clr -> err=0 next cycle.
REQ-026 Scenario: rst asserted in 2nd PULSE cycle -> latch_s=0 next edge, no ack, busy=0, later set_req completes normally.
REQ-027 Scenario: set_req repeated three times during a busy set operation -> exactly one additional set operation follows.
REQ-028 Scenario: mismatch and err_clr same cycle -> err remains 1.
